// File: rtl/scene_bus_reader_pkg.sv
// Shared definitions for the scene bus reader: bus layout, point/vector types, FSM states.
// Field order of snap_t mirrors scene_bus[115:0] so a snapshot is a straight cast of the bus.
package scene_pkg;

    localparam int BUS_W        = 128;
    localparam int RESERVED_LSB = 116;
    localparam int EYE_LSB      = 0;
    localparam int PT_W         = 28;
    localparam int NRM_LSB      = 28;
    localparam int NRM_W        = 31;
    localparam int VD_LSB       = 59;
    localparam int VD_W         = 8;
    localparam int LEN_BIT      = 67;
    localparam int CTR_LSB      = 68;
    localparam int RAD_LSB      = 96;
    localparam int RAD_W        = 8;
    localparam int COL_LSB      = 104;
    localparam int COL_W        = 12;
    localparam int PROD_W       = 22;
    localparam int ACC_W        = 23;
    localparam int RSQ_W        = 16;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] z;
    } point_t;

    typedef struct packed {
        logic signed [10:0] x;
        logic signed [10:0] y;
        logic signed [8:0]  z;
    } vec_t;

    typedef struct packed {
        logic [COL_W-1:0] color;
        logic [RAD_W-1:0] radius;
        point_t           center;
        logic             light_en;
        logic [VD_W-1:0]  view_dist;
        vec_t             normal;
        point_t           eye;
    } snap_t;

    typedef enum logic [2:0] {
        S_IDLE, S_CAPTURE, S_MUL0, S_MUL1, S_MUL2, S_MUL3, S_DONE
    } state_e;

    // Zero-extend both points by one bit so the difference is an exact signed delta.
    function automatic vec_t rel_vec(input point_t c, input point_t e);
        vec_t v;
        v.x = {1'b0, c.x} - {1'b0, e.x};
        v.y = {1'b0, c.y} - {1'b0, e.y};
        v.z = {1'b0, c.z} - {1'b0, e.z};
        return v;
    endfunction

endpackage

// File: rtl/scene_bus_reader_if.sv
// Scene bus input, frame request and the tracer-facing published scene with valid/ready.
interface scene_bus_reader_if;
    logic [scene_pkg::BUS_W-1:0] scene_bus;
    logic                        frame_start;
    logic                        scene_ready;
    logic                        scene_valid;
    logic                        busy;
    logic                        scene_skip;
    logic [27:0]                 eye;
    logic [30:0]                 normal;
    logic [7:0]                  view_dist;
    logic                        light_en;
    logic [27:0]                 sph_center;
    logic [7:0]                  sph_radius;
    logic [11:0]                 sph_color;
    logic signed [10:0]          rel_dx;
    logic signed [10:0]          rel_dy;
    logic signed [8:0]           rel_dz;
    logic [15:0]                 radius_sq;
    logic signed [22:0]          c_term;

    modport master (
        output scene_bus, frame_start, scene_ready,
        input  scene_valid, busy, scene_skip, eye, normal, view_dist, light_en,
               sph_center, sph_radius, sph_color, rel_dx, rel_dy, rel_dz, radius_sq, c_term
    );

    modport slave (
        input  scene_bus, frame_start, scene_ready,
        output scene_valid, busy, scene_skip, eye, normal, view_dist, light_en,
               sph_center, sph_radius, sph_color, rel_dx, rel_dy, rel_dz, radius_sq, c_term
    );
endinterface

// File: rtl/scene_bus_reader_sq_mac.sv
// Single shared signed 11x11 squarer with a 23-bit add/subtract accumulator.
// sel 0..2 square the relative deltas, sel 3 squares the radius and is subtracted.
module scene_sq_mac
    import scene_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [1:0]        sel_i,
    input  vec_t              rel_i,
    input  logic [RAD_W-1:0]  r_i,
    output logic [RSQ_W-1:0]  sq_lo_o,
    output logic signed [ACC_W-1:0] acc_o
);
    logic signed [10:0]       op;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_x;
    logic signed [ACC_W-1:0]  acc_q, acc_d;

    always_comb begin
        op = '0;
        case (sel_i)
            2'd0:    op = rel_i.x;
            2'd1:    op = rel_i.y;
            2'd2:    op = {{2{rel_i.z[8]}}, rel_i.z};
            default: op = {3'b000, r_i};
        endcase
    end

    assign prod   = op * op;
    assign prod_x = {prod[PROD_W-1], prod};

    always_comb begin
        acc_d = acc_q;
        if (clr_i)
            acc_d = '0;
        else if (en_i)
            acc_d = (sel_i == 2'd3) ? acc_q - prod_x : acc_q + prod_x;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end

    assign sq_lo_o = prod[RSQ_W-1:0];
    assign acc_o   = acc_q;
endmodule

// File: rtl/scene_bus_reader.sv
// Snapshots the scene bus on frame_start, derives eye-to-sphere terms and publishes them.
// Optional SCENE_CHANGE_DET_EN: an unchanged snapshot pulses scene_skip instead of republishing.
module scene_bus_reader
    import scene_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    scene_bus_reader_if.slave sb
);
    state_e state_q, state_d;
    logic   pend_q, pend_d;

    snap_t  bus_snap, shadow_q, pub_q;
    vec_t   rel_q, pub_rel_q;
    logic [RSQ_W-1:0]        rsq_q, pub_rsq_q, sq_lo;
    logic signed [ACC_W-1:0] acc, pub_c_q;
    logic   valid_q;

    logic   cap_en, mac_clr, mac_en, rsq_en, pub_en, done_ack, skip_hit;
    logic [1:0] mac_sel;

    assign bus_snap = snap_t'(sb.scene_bus[RESERVED_LSB-1:0]);
    assign done_ack = (state_q == S_DONE) && valid_q && sb.scene_ready;

`ifdef SCENE_CHANGE_DET_EN
    logic pubd_q, skip_q;

    // Nothing to compare against until the first publish after reset.
    assign skip_hit = pubd_q && (bus_snap == pub_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pubd_q <= 1'b0;
            skip_q <= 1'b0;
        end else begin
            pubd_q <= pubd_q | pub_en;
            skip_q <= (state_q == S_CAPTURE) && skip_hit;
        end
    end

    assign sb.scene_skip = skip_q;
`else
    assign skip_hit      = 1'b0;
    assign sb.scene_skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // Requests arriving while busy collapse into one pending flag, serviced from IDLE.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q | ((state_q != S_IDLE) && sb.frame_start);
        case (state_q)
            S_IDLE: begin
                pend_d = 1'b0;
                if (sb.frame_start || pend_q) state_d = S_CAPTURE;
            end
            S_CAPTURE: state_d = skip_hit ? S_IDLE : S_MUL0;
            S_MUL0:    state_d = S_MUL1;
            S_MUL1:    state_d = S_MUL2;
            S_MUL2:    state_d = S_MUL3;
            S_MUL3:    state_d = S_DONE;
            S_DONE:    if (done_ack) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cap_en  = 1'b0;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        mac_sel = 2'd0;
        rsq_en  = 1'b0;
        pub_en  = 1'b0;
        case (state_q)
            S_CAPTURE: begin cap_en = 1'b1; mac_clr = 1'b1; end
            S_MUL0:    begin mac_en = 1'b1; mac_sel = 2'd0; end
            S_MUL1:    begin mac_en = 1'b1; mac_sel = 2'd1; end
            S_MUL2:    begin mac_en = 1'b1; mac_sel = 2'd2; end
            S_MUL3:    begin mac_en = 1'b1; mac_sel = 2'd3; rsq_en = 1'b1; end
            S_DONE:    pub_en = !valid_q;
            default:   ;
        endcase
    end

    assign sb.busy = (state_q != S_IDLE);

    scene_sq_mac u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (mac_clr),
        .en_i    (mac_en),
        .sel_i   (mac_sel),
        .rel_i   (rel_q),
        .r_i     (shadow_q.radius),
        .sq_lo_o (sq_lo),
        .acc_o   (acc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            rel_q     <= '0;
            rsq_q     <= '0;
            pub_q     <= '0;
            pub_rel_q <= '0;
            pub_rsq_q <= '0;
            pub_c_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            if (cap_en) begin
                shadow_q <= bus_snap;
                rel_q    <= rel_vec(bus_snap.center, bus_snap.eye);
            end
            if (rsq_en) rsq_q <= sq_lo;
            // Published copies move only here, so they stay stable through DONE and IDLE.
            if (pub_en) begin
                pub_q     <= shadow_q;
                pub_rel_q <= rel_q;
                pub_rsq_q <= rsq_q;
                pub_c_q   <= acc;
                valid_q   <= 1'b1;
            end else if (done_ack) begin
                valid_q   <= 1'b0;
            end
        end
    end

    assign sb.scene_valid = valid_q;
    assign sb.eye         = pub_q.eye;
    assign sb.normal      = pub_q.normal;
    assign sb.view_dist   = pub_q.view_dist;
    assign sb.light_en    = pub_q.light_en;
    assign sb.sph_center  = pub_q.center;
    assign sb.sph_radius  = pub_q.radius;
    assign sb.sph_color   = pub_q.color;
    assign sb.rel_dx      = pub_rel_q.x;
    assign sb.rel_dy      = pub_rel_q.y;
    assign sb.rel_dz      = pub_rel_q.z;
    assign sb.radius_sq   = pub_rsq_q;
    assign sb.c_term      = pub_c_q;
endmodule
